// File: rtl/stage_evaluator.sv
// Consumer side of the classifier-ROM sequencer: buffers weak-classifier words, fetches features,
// accumulates leaf values per stage and issues next-stage / break / face / reject decisions.
module stage_evaluator #(
    parameter int VAL_W      = 16,
    parameter int SUM_W      = 20,
    parameter int IDX_W      = 12,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               win_val_i,
    input  logic               abort_i,
    input  logic [3*VAL_W-1:0] rom_data_i,
    input  logic               rom_val_i,
    input  logic               stage_val_i,
    input  logic               stage_last_i,
    output logic               wait_o,
    output logic               next_stage_o,
    output logic               break_o,
    // feat_req_o/feat_idx_o stay stable until the cycle feat_ack_i is seen high; that cycle completes the transfer.
    output logic               feat_req_o,
    output logic [IDX_W-1:0]   feat_idx_o,
    input  logic               feat_ack_i,
    input  logic [VAL_W-1:0]   feat_val_i,
    output logic               face_o,
    output logic               reject_o,
    output logic [4:0]         stage_num_o,
    output logic               err_o,
    output logic [1:0]         state_o,
    output logic [1:0]         fifo_count_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        FEAT   = 2'd2,
        DECIDE = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [3*VAL_W-1:0]       fifo_mem [FIFO_DEPTH];
    logic                     wr_ptr, rd_ptr;
    logic [1:0]               fifo_count;
    logic                     fifo_full, push_req, push, pop, flush;
    logic signed [VAL_W-1:0]  node_thr, left_val, right_val, feat_val, leaf;
    logic signed [SUM_W-1:0]  acc, leaf_ext, stage_thr;
    logic [IDX_W-1:0]         idx;
    logic [4:0]               stage_num;
    logic                     err;
    logic                     acc_clr, acc_add, idx_clr, idx_inc, stage_clr, stage_inc;

    // Words are only accepted inside a window; a word racing an abort belongs to the dropped window.
    assign fifo_full = (fifo_count == 2'(FIFO_DEPTH));
    assign push_req  = rom_val_i && (state_q != IDLE) && !abort_i;
    assign push      = push_req && !fifo_full;

    assign feat_val  = feat_val_i;
    assign leaf      = (feat_val < node_thr) ? left_val : right_val;
    assign leaf_ext  = {{(SUM_W-VAL_W){leaf[VAL_W-1]}}, leaf};
    assign stage_thr = {{(SUM_W-VAL_W){rom_data_i[VAL_W-1]}}, rom_data_i[VAL_W-1:0]};

    assign feat_req_o   = (state_q == FEAT);
    assign wait_o       = (state_q == IDLE) || (fifo_count != 2'd0) || feat_req_o;
    assign feat_idx_o   = idx;
    assign stage_num_o  = stage_num;
    assign err_o        = err;
    assign state_o      = state_q;
    assign fifo_count_o = fifo_count;

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        flush        = 1'b0;
        acc_clr      = 1'b0;
        acc_add      = 1'b0;
        idx_clr      = 1'b0;
        idx_inc      = 1'b0;
        stage_clr    = 1'b0;
        stage_inc    = 1'b0;
        next_stage_o = 1'b0;
        break_o      = 1'b0;
        face_o       = 1'b0;
        reject_o     = 1'b0;
        if (rst_i) begin
            state_d = IDLE;
        end else if ((state_q != IDLE) && abort_i) begin
            flush   = 1'b1;
            break_o = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_val_i) begin
                        acc_clr   = 1'b1;
                        idx_clr   = 1'b1;
                        stage_clr = 1'b1;
                        state_d   = FETCH;
                    end
                end
                FETCH: begin
                    if (fifo_count != 2'd0) begin
                        pop     = 1'b1;
                        state_d = FEAT;
                    end else if (stage_val_i) begin
                        state_d = DECIDE;
                    end
                end
                FEAT: begin
                    if (feat_ack_i) begin
                        acc_add = 1'b1;
                        idx_inc = 1'b1;
                        state_d = FETCH;
                    end
                end
                DECIDE: begin
                    if (acc >= stage_thr) begin
                        if (stage_last_i) begin
                            face_o  = 1'b1;
                            break_o = 1'b1;
                            state_d = IDLE;
                        end else begin
                            next_stage_o = 1'b1;
                            stage_inc    = 1'b1;
                            acc_clr      = 1'b1;
                            state_d      = FETCH;
                        end
                    end else begin
                        reject_o = 1'b1;
                        break_o  = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            err        <= 1'b0;
        end else begin
            if (push_req && fifo_full) begin
                err <= 1'b1;
            end
            if (flush) begin
                wr_ptr     <= 1'b0;
                rd_ptr     <= 1'b0;
                fifo_count <= 2'd0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
                if (push && !pop) begin
                    fifo_count <= fifo_count + 2'd1;
                end else if (pop && !push) begin
                    fifo_count <= fifo_count - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= rom_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            node_thr  <= '0;
            left_val  <= '0;
            right_val <= '0;
            acc       <= '0;
            idx       <= '0;
            stage_num <= '0;
        end else begin
            if (pop) begin
                {node_thr, left_val, right_val} <= fifo_mem[rd_ptr];
            end
            if (acc_clr) begin
                acc <= '0;
            end else if (acc_add) begin
                acc <= acc + leaf_ext;
            end
            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + 1'b1;
            end
            if (stage_clr) begin
                stage_num <= '0;
            end else if (stage_inc) begin
                stage_num <= stage_num + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_stage_evaluator.sv
// Bench for stage_evaluator: a sequencer/feature-unit driver, a per-window verdict model,
// table vectors, randomized windows and hand-written abort/overflow/reset sequences.
module tb_stage_evaluator;

    localparam int VAL_W = 16;
    localparam int SUM_W = 20;
    localparam int IDX_W = 12;

    logic               clk = 1'b0;
    logic               rst_i, win_val_i, abort_i;
    logic [3*VAL_W-1:0] rom_data_i;
    logic               rom_val_i, stage_val_i, stage_last_i;
    logic               wait_o, next_stage_o, break_o, feat_req_o;
    logic [IDX_W-1:0]   feat_idx_o;
    logic               feat_ack_i;
    logic [VAL_W-1:0]   feat_val_i;
    logic               face_o, reject_o;
    logic [4:0]         stage_num_o;
    logic               err_o;
    logic [1:0]         state_o, fifo_count_o;

    stage_evaluator #(.VAL_W(VAL_W), .SUM_W(SUM_W), .IDX_W(IDX_W), .FIFO_DEPTH(2)) dut (
        .clk_i(clk), .rst_i(rst_i), .win_val_i(win_val_i), .abort_i(abort_i),
        .rom_data_i(rom_data_i), .rom_val_i(rom_val_i), .stage_val_i(stage_val_i),
        .stage_last_i(stage_last_i), .wait_o(wait_o), .next_stage_o(next_stage_o),
        .break_o(break_o), .feat_req_o(feat_req_o), .feat_idx_o(feat_idx_o),
        .feat_ack_i(feat_ack_i), .feat_val_i(feat_val_i), .face_o(face_o),
        .reject_o(reject_o), .stage_num_o(stage_num_o), .err_o(err_o),
        .state_o(state_o), .fifo_count_o(fifo_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nthr, left, right, f0, f1, sthr, last, term_thr;
        int e_next, e_face, e_rej, e_stage;
    } vec_t;

    vec_t vecs[8];

    // Window description: stages of weak words, features indexed by global word index
    int n_words[8];
    int s_thr[8];
    int ns;
    int w_nthr[64], w_left[64], w_right[64], w_feat[64];
    logic [IDX_W-1:0] exp_q[$];

    int errors = 0;
    int checks = 0;
    int obs_next, obs_face, obs_rej, obs_brk, obs_both, obs_stage, obs_peak, obs_done;
    int e_next, e_face, e_rej, e_stage;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic drive_idle();
        win_val_i    = 1'b0;
        abort_i      = 1'b0;
        rom_data_i   = '0;
        rom_val_i    = 1'b0;
        stage_val_i  = 1'b0;
        stage_last_i = 1'b0;
        feat_ack_i   = 1'b0;
        feat_val_i   = '0;
    endtask

    task automatic set_word(input int k);
        rom_data_i = {VAL_W'(w_nthr[k]), VAL_W'(w_left[k]), VAL_W'(w_right[k])};
    endtask

    // Reference: walk the stages, sum the chosen leaves, stop at the first failing or final stage.
    task automatic compute_expected();
        logic signed [SUM_W-1:0] acc_m, t_m;
        int k, leaf;
        k = 0;
        e_next = 0; e_face = 0; e_rej = 0; e_stage = 0;
        exp_q.delete();
        for (int s = 0; s < ns; s++) begin
            acc_m = '0;
            for (int j = 0; j < n_words[s]; j++) begin
                leaf  = (w_feat[k] < w_nthr[k]) ? w_left[k] : w_right[k];
                acc_m = acc_m + SUM_W'(leaf);
                exp_q.push_back(IDX_W'(k));
                k++;
            end
            t_m = SUM_W'(s_thr[s]);
            if (acc_m >= t_m) begin
                if (s == ns - 1) begin
                    e_face = 1; e_stage = s;
                    break;
                end
                e_next++;
            end else begin
                e_rej = 1; e_stage = s;
                break;
            end
        end
    endtask

    // Acts as sequencer and feature unit for one window until break_o.
    task automatic run_window(input int dly_mode, input bit abort_decide, input bit burst);
        int st, w, base, cyc, last_ack, dly, fi;
        bit req_seen, acked;
        obs_next = 0; obs_face = 0; obs_rej = 0; obs_brk = 0; obs_both = 0;
        obs_stage = -1; obs_peak = 0; obs_done = 0;
        st = 0; w = 0; base = 0; cyc = 0; last_ack = -100; dly = 0;
        req_seen = 1'b0; acked = 1'b0;
        @(negedge clk);
        drive_idle();
        win_val_i = 1'b1;
        while (obs_done == 0 && cyc < 3000) begin
            @(negedge clk);
            drive_idle();
            cyc++;
            if (w < n_words[st]) begin
                if (burst || !wait_o) begin
                    rom_val_i = 1'b1;
                    set_word(base + w);
                    w++;
                end
            end else begin
                stage_val_i               = 1'b1;
                rom_data_i[VAL_W-1:0]     = VAL_W'(s_thr[st]);
                stage_last_i              = (st == ns - 1);
                if (abort_decide && state_o == 2'd3) abort_i = 1'b1;
            end
            if (feat_req_o) begin
                if (!req_seen) begin
                    req_seen = 1'b1;
                    acked    = 1'b0;
                    dly      = (dly_mode < 0) ? int'($urandom_range(0, 3)) : dly_mode;
                end
                if (!acked) begin
                    if (dly == 0) begin
                        fi         = int'(feat_idx_o);
                        feat_ack_i = 1'b1;
                        feat_val_i = (fi < 64) ? VAL_W'(w_feat[fi]) : '0;
                        acked      = 1'b1;
                        last_ack   = cyc;
                        if (exp_q.size() == 0) check("extra_feat_req", 1, 0);
                        else check("feat_idx", feat_idx_o, exp_q.pop_front());
                    end else begin
                        dly--;
                    end
                end
            end else begin
                req_seen = 1'b0;
            end
            #1;
            if (int'(fifo_count_o) > obs_peak) obs_peak = int'(fifo_count_o);
            if (next_stage_o && break_o) obs_both++;
            if (face_o) begin obs_face++; obs_stage = int'(stage_num_o); end
            if (reject_o) begin obs_rej++; obs_stage = int'(stage_num_o); end
            if (next_stage_o) begin
                obs_next++;
                if (n_words[st] > 0) check("ack_to_next_latency", cyc - last_ack, 2);
                base += n_words[st];
                st++;
                w = 0;
                if (st >= ns) obs_done = 1;
            end
            if (break_o) begin
                obs_brk++;
                obs_done = 1;
            end
        end
        check("window_done", obs_done, 1);
        @(negedge clk);
        drive_idle();
    endtask

    task automatic check_window(input string tag, input int x_next, input int x_face,
                                input int x_rej, input int x_stage);
        check({tag, "_next"}, obs_next, x_next);
        check({tag, "_face"}, obs_face, x_face);
        check({tag, "_reject"}, obs_rej, x_rej);
        check({tag, "_break"}, obs_brk, 1);
        check({tag, "_next_and_break"}, obs_both, 0);
        check({tag, "_reqs_left"}, exp_q.size(), 0);
        if (x_face + x_rej > 0) check({tag, "_stage_num"}, obs_stage, x_stage);
        check({tag, "_idle"}, state_o, 0);
        check({tag, "_wait"}, wait_o, 1);
    endtask

    task automatic load_vec(input vec_t v);
        ns          = (v.last != 0) ? 1 : 2;
        n_words[0]  = 2;
        n_words[1]  = 0;
        for (int i = 0; i < 2; i++) begin
            w_nthr[i]  = v.nthr;
            w_left[i]  = v.left;
            w_right[i] = v.right;
        end
        w_feat[0] = v.f0;
        w_feat[1] = v.f1;
        s_thr[0]  = v.sthr;
        s_thr[1]  = v.term_thr;
    endtask

    initial begin
        //            nthr  left right  f0   f1  sthr last term  next face rej stage
        vecs[0] = '{  10,   -5,    7,    3,  12,    1,  0,    1,    1,   0,  1,   1};
        vecs[1] = '{  10,   -5,    7,    3,  12,    3,  0,    0,    0,   0,  1,   0};
        vecs[2] = '{  10,   -5,    7,    3,  12,    1,  1,    0,    0,   1,  0,   0};
        vecs[3] = '{  10,   -5,    7,    3,  12,    2,  1,    0,    0,   1,  0,   0};
        vecs[4] = '{  10,   -5,    7,   12,  12,   15,  1,    0,    0,   0,  1,   0};
        vecs[5] = '{  10,   -5,    7,    3,   3,  -10,  0,    0,    1,   1,  0,   1};
        vecs[6] = '{  10,   -5,    7,   10,   9,    3,  1,    0,    0,   0,  1,   0};
        vecs[7] = '{-100,  300, -400, -200,-100, -101,  1,    0,    0,   1,  0,   0};

        // Reset state
        drive_idle();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cycle_break", break_o, 0);
        check("rst_cycle_face", face_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("rst_state", state_o, 0);
        check("rst_wait", wait_o, 1);
        check("rst_feat_req", feat_req_o, 0);
        check("rst_err", err_o, 0);
        check("rst_stage_num", stage_num_o, 0);
        check("rst_fifo", fifo_count_o, 0);
        check("rst_pulses", {next_stage_o, break_o, face_o, reject_o}, 0);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            load_vec(vecs[i]);
            compute_expected();
            run_window(0, 1'b0, 1'b0);
            check_window($sformatf("vec%0d", i), vecs[i].e_next, vecs[i].e_face,
                         vecs[i].e_rej, vecs[i].e_stage);
        end

        // Slow feature unit while the ROM keeps streaming: FIFO fills to 2 without overflow
        ns = 1; n_words[0] = 3; s_thr[0] = -3;
        for (int i = 0; i < 3; i++) begin
            w_nthr[i] = 10; w_left[i] = -5; w_right[i] = 7;
        end
        w_feat[0] = 3; w_feat[1] = 12; w_feat[2] = 3;
        compute_expected();
        run_window(5, 1'b0, 1'b1);
        check_window("burst", 0, 1, 0, 0);
        check("burst_fifo_peak", obs_peak, 2);
        check("burst_err", err_o, 0);

        // Overflow: keep pushing into a full FIFO, err_o must stick through abort and a new window
        @(negedge clk);
        drive_idle();
        win_val_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_idle();
            rom_val_i = 1'b1;
            set_word(0);
        end
        @(negedge clk);
        drive_idle();
        #1;
        check("ovf_err", err_o, 1);
        check("ovf_fifo", fifo_count_o, 2);
        check("ovf_wait", wait_o, 1);
        abort_i = 1'b1;
        #1;
        check("ovf_abort_break", break_o, 1);
        check("ovf_abort_verdict", {face_o, reject_o, next_stage_o}, 0);
        @(negedge clk);
        drive_idle();
        check("ovf_abort_idle", state_o, 0);
        check("ovf_abort_fifo", fifo_count_o, 0);
        check("ovf_err_sticky", err_o, 1);
        load_vec(vecs[2]);
        compute_expected();
        run_window(1, 1'b0, 1'b0);
        check_window("after_ovf", 0, 1, 0, 0);
        check("ovf_err_sticky2", err_o, 1);

        // Reset mid-operation (with abort held): no pulses in the reset cycle, everything cleared
        @(negedge clk);
        win_val_i = 1'b1;
        @(negedge clk);
        drive_idle();
        rom_val_i = 1'b1;
        set_word(0);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        check("midrst_in_feat", feat_req_o, 1);
        rst_i   = 1'b1;
        abort_i = 1'b1;
        #1;
        check("midrst_no_pulse", {next_stage_o, break_o, face_o, reject_o}, 0);
        @(negedge clk);
        drive_idle();
        rst_i = 1'b0;
        check("midrst_state", state_o, 0);
        check("midrst_err", err_o, 0);
        check("midrst_feat_req", feat_req_o, 0);
        check("midrst_fifo", fifo_count_o, 0);

        // Abort while waiting for a feature, then a late ack that must be ignored
        @(negedge clk);
        win_val_i = 1'b1;
        @(negedge clk);
        drive_idle();
        rom_val_i = 1'b1;
        rom_data_i = {VAL_W'(10), VAL_W'(-5), VAL_W'(7)};
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        check("abort_in_feat", feat_req_o, 1);
        abort_i = 1'b1;
        #1;
        check("abort_break", break_o, 1);
        check("abort_no_verdict", {face_o, reject_o, next_stage_o}, 0);
        @(negedge clk);
        drive_idle();
        feat_ack_i = 1'b1;
        feat_val_i = VAL_W'(3);
        #1;
        check("abort_idle", state_o, 0);
        check("abort_req_dropped", feat_req_o, 0);
        @(negedge clk);
        drive_idle();
        check("late_ack_ignored", state_o, 0);
        load_vec(vecs[0]);
        compute_expected();
        run_window(2, 1'b0, 1'b0);
        check_window("after_abort", 1, 0, 1, 1);

        // Abort coinciding with DECIDE suppresses the verdict
        load_vec(vecs[2]);
        compute_expected();
        run_window(0, 1'b1, 1'b0);
        check_window("abort_decide", 0, 0, 0, 0);

        // Randomized windows against the model
        for (int r = 0; r < 25; r++) begin
            int k, sum;
            ns = int'($urandom_range(1, 3));
            k  = 0;
            for (int s = 0; s < ns; s++) begin
                n_words[s] = int'($urandom_range(1, 4));
                sum = 0;
                for (int j = 0; j < n_words[s]; j++) begin
                    w_nthr[k]  = int'($urandom_range(0, 200)) - 100;
                    w_left[k]  = int'($urandom_range(0, 2000)) - 1000;
                    w_right[k] = int'($urandom_range(0, 2000)) - 1000;
                    w_feat[k]  = w_nthr[k] + int'($urandom_range(0, 4)) - 2;
                    sum += (w_feat[k] < w_nthr[k]) ? w_left[k] : w_right[k];
                    k++;
                end
                s_thr[s] = sum + int'($urandom_range(0, 2)) - 1;
            end
            compute_expected();
            run_window(-1, 1'b0, 1'b0);
            check_window($sformatf("rand%0d", r), e_next, e_face, e_rej, e_stage);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
